// File: rtl/alu_exception_unit.sv
// alu_exception_unit
//
// Sits after the ALU in the EX stage. It does three jobs:
//   - registers each ALU result toward writeback (1-cycle latency)
//   - OR-accumulates the ALU status flags into a sticky status register
//   - detects trapping ops (signed overflow on add/sub/mul, divide-by-zero
//     on div), captures EPC and cause, and holds the pipeline until the
//     control unit acknowledges.
//
// Handshake: exc_req is a level request. It rises on the edge after a
// trapping op is accepted and stays high, together with stall, until the
// edge at which exc_ack=1 is sampled while in TRAP. exc_ack in IDLE has
// no effect. While in TRAP, ex_valid is ignored.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ex_valid          ALU result/status/ctrl/pc valid this cycle
//   ex_ctrl           ALU op code (0010 add, 0110 sub, 1000 mul, 1001 div)
//   ex_result         ALU result
//   ex_status         ALU flags: [7] zero [6] ovf [5] carry [4] neg [2] div0
//   ex_pc             PC of the instruction
//   trap_mask         [0] enable overflow trap, [1] enable div-by-zero trap
//   status_clr        clear sticky status (set-after-clear with a new op)
//   exc_ack           control unit acknowledges the exception
//   wb_valid/result   registered writeback
//   stall             hold upstream pipeline (state == TRAP)
//   exc_req           exception request to control unit
//   exc_cause         00 none, 01 overflow, 10 divide-by-zero
//   epc               PC of faulting instruction
//   sticky_status     accumulated flags; bits [3],[1],[0] always 0
//   exc_count         trap counter (only with ALU_EXC_COUNTER_EN, else 0)
//   dbg_state         current FSM state (0 IDLE, 1 TRAP)
//
// Optional feature macro: ALU_EXC_COUNTER_EN
module alu_exception_unit #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [3:0]        ex_ctrl,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [7:0]        ex_status,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [1:0]        trap_mask,
  input  logic              status_clr,
  input  logic              exc_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic              exc_req,
  output logic [1:0]        exc_cause,
  output logic [PC_W-1:0]   epc,
  output logic [7:0]        sticky_status,
  output logic [CNT_W-1:0]  exc_count,
  output logic              dbg_state
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_MUL = 4'b1000;
  localparam logic [3:0] CTRL_DIV = 4'b1001;

  // Only zero, overflow, carry, negative and divide-by-zero are tracked.
  localparam logic [7:0] STATUS_MASK = 8'b1111_0100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wb_valid;
  logic [DATA_W-1:0]   r_wb_result;
  logic                r_exc_req;
  logic [1:0]          r_exc_cause;
  logic [PC_W-1:0]     r_epc;
  logic [7:0]          r_sticky;

  logic                w_accept;
  logic                w_ovf_op;
  logic                w_ovf_trap;
  logic                w_dz_trap;
  logic                w_trap;
  logic [1:0]          w_cause;
  logic [7:0]          w_status_m;

  assign w_accept   = ex_valid && (r_state == ST_IDLE);
  assign w_ovf_op   = (ex_ctrl == CTRL_ADD) || (ex_ctrl == CTRL_SUB) ||
                      (ex_ctrl == CTRL_MUL);
  assign w_ovf_trap = ex_status[6] && trap_mask[0] && w_ovf_op;
  assign w_dz_trap  = ex_status[2] && trap_mask[1] && (ex_ctrl == CTRL_DIV);
  assign w_trap     = w_accept && (w_ovf_trap || w_dz_trap);
  // Divide-by-zero takes priority when both conditions hold.
  assign w_cause    = w_dz_trap ? 2'b10 : 2'b01;
  assign w_status_m = ex_status & STATUS_MASK;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_trap)  w_state_nxt = ST_TRAP;
      ST_TRAP: if (exc_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wb_valid  <= 1'b0;
      r_wb_result <= '0;
      r_exc_req   <= 1'b0;
      r_exc_cause <= 2'b00;
      r_epc       <= '0;
      r_sticky    <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= w_accept && !w_trap;
      if (w_accept && !w_trap) r_wb_result <= ex_result;

      if (w_trap) begin
        r_exc_req   <= 1'b1;
        r_exc_cause <= w_cause;
        r_epc       <= ex_pc;
      end else if (r_state == ST_TRAP && exc_ack) begin
        r_exc_req   <= 1'b0;
        r_exc_cause <= 2'b00;
      end

      // Clear first, then merge the flags of an op accepted in the same cycle.
      if (status_clr) r_sticky <= w_accept ? w_status_m : 8'h00;
      else if (w_accept) r_sticky <= r_sticky | w_status_m;
    end
  end

`ifdef ALU_EXC_COUNTER_EN
  logic [CNT_W-1:0] r_exc_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_count <= '0;
    end else if (w_trap && !(&r_exc_count)) begin
      r_exc_count <= r_exc_count + 1'b1;
    end
  end

  assign exc_count = r_exc_count;
`else
  assign exc_count = '0;
`endif

  assign wb_valid      = r_wb_valid;
  assign wb_result     = r_wb_result;
  assign stall         = (r_state == ST_TRAP);
  assign exc_req       = r_exc_req;
  assign exc_cause     = r_exc_cause;
  assign epc           = r_epc;
  assign sticky_status = r_sticky;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Directed, table-driven bench for alu_exception_unit. Each record holds the
// inputs driven for one cycle and the outputs expected after the next edge.
module tb_alu_exception_unit;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 16;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] MUL = 4'b1000;
  localparam logic [3:0] DIV = 4'b1001;

  logic              clk;
  logic              reset;
  logic              ex_valid;
  logic [3:0]        ex_ctrl;
  logic [DATA_W-1:0] ex_result;
  logic [7:0]        ex_status;
  logic [PC_W-1:0]   ex_pc;
  logic [1:0]        trap_mask;
  logic              status_clr;
  logic              exc_ack;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_result;
  logic              stall;
  logic              exc_req;
  logic [1:0]        exc_cause;
  logic [PC_W-1:0]   epc;
  logic [7:0]        sticky_status;
  logic [CNT_W-1:0]  exc_count;
  logic              dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exception_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_result(ex_result), .ex_status(ex_status), .ex_pc(ex_pc),
    .trap_mask(trap_mask), .status_clr(status_clr), .exc_ack(exc_ack),
    .wb_valid(wb_valid), .wb_result(wb_result), .stall(stall),
    .exc_req(exc_req), .exc_cause(exc_cause), .epc(epc),
    .sticky_status(sticky_status), .exc_count(exc_count),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic [7:0]  status;
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        clr;
    logic        ack;
    logic        e_wbv;
    logic [31:0] e_wbr;
    logic        e_stall;
    logic        e_req;
    logic [1:0]  e_cause;
    logic [31:0] e_epc;
    logic [7:0]  e_sticky;
    int          e_cnt;   // traps taken so far (used only with the counter)
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic valid, input logic [3:0] ctrl, input logic [31:0] res,
    input logic [7:0] status, input logic [31:0] pc, input logic [1:0] mask,
    input logic clr, input logic ack,
    input logic e_wbv, input logic [31:0] e_wbr, input logic e_stall,
    input logic e_req, input logic [1:0] e_cause, input logic [31:0] e_epc,
    input logic [7:0] e_sticky, input int e_cnt);
    vec_t v;
    v.valid = valid; v.ctrl = ctrl; v.res = res; v.status = status;
    v.pc = pc; v.mask = mask; v.clr = clr; v.ack = ack;
    v.e_wbv = e_wbv; v.e_wbr = e_wbr; v.e_stall = e_stall; v.e_req = e_req;
    v.e_cause = e_cause; v.e_epc = e_epc; v.e_sticky = e_sticky;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_count(input int traps);
`ifdef ALU_EXC_COUNTER_EN
    return traps;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".wb_valid"},  64'(wb_valid),      64'(v.e_wbv));
    check({tag, ".wb_result"}, 64'(wb_result),     64'(v.e_wbr));
    check({tag, ".stall"},     64'(stall),         64'(v.e_stall));
    check({tag, ".dbg_state"}, 64'(dbg_state),     64'(v.e_stall));
    check({tag, ".exc_req"},   64'(exc_req),       64'(v.e_req));
    check({tag, ".exc_cause"}, 64'(exc_cause),     64'(v.e_cause));
    check({tag, ".epc"},       64'(epc),           64'(v.e_epc));
    check({tag, ".sticky"},    64'(sticky_status), 64'(v.e_sticky));
    check({tag, ".exc_count"}, 64'(exc_count),     64'(exp_count(v.e_cnt)));
  endtask

  // Driver: apply one record just after an edge, sample just after the next.
  task automatic drive(input vec_t v);
    ex_valid   = v.valid;
    ex_ctrl    = v.ctrl;
    ex_result  = v.res;
    ex_status  = v.status;
    ex_pc      = v.pc;
    trap_mask  = v.mask;
    status_clr = v.clr;
    exc_ack    = v.ack;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_ctrl = 4'h0; ex_result = '0; ex_status = 8'h00;
    ex_pc = '0; trap_mask = 2'b00; status_clr = 0; exc_ack = 0;
  endtask

  vec_t zero_v;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    zero_v = mk(0, 4'h0, 0, 8'h00, 0, 2'b00, 0, 0,
                0, 32'h0, 0, 0, 2'b00, 32'h0, 8'h00, 0);
    check_outputs("reset", zero_v);
    reset = 1'b0;

    //           v  ctrl res           status pc            mask clr ack | wbv wbr           stl req cause epc           sticky cnt
    vecs.push_back(mk(1, ADD, 32'h0000_0005, 8'h00, 32'h0000_0100, 2'b00, 0, 0, 1, 32'h0000_0005, 0, 0, 2'b00, 32'h0,         8'h00, 0));
    vecs.push_back(mk(1, ADD, 32'h0000_DEAD, 8'h50, 32'h0040_0010, 2'b01, 0, 0, 0, 32'h0000_0005, 1, 1, 2'b01, 32'h0040_0010, 8'h50, 1));
    for (int i = 0; i < 3; i++)  // ex_valid ignored while trapped
      vecs.push_back(mk(1, ADD, 32'h0000_0077, 8'hC4, 32'h0000_0500, 2'b01, 0, 0, 0, 32'h0000_0005, 1, 1, 2'b01, 32'h0040_0010, 8'h50, 1));
    vecs.push_back(mk(0, ADD, 32'h0,         8'h00, 32'h0,         2'b01, 0, 1, 0, 32'h0000_0005, 0, 0, 2'b00, 32'h0040_0010, 8'h50, 1));
    vecs.push_back(mk(0, ADD, 32'h0,         8'h00, 32'h0,         2'b01, 0, 1, 0, 32'h0000_0005, 0, 0, 2'b00, 32'h0040_0010, 8'h50, 1));
    vecs.push_back(mk(1, DIV, 32'h0000_0099, 8'h44, 32'h0040_0020, 2'b11, 0, 0, 0, 32'h0000_0005, 1, 1, 2'b10, 32'h0040_0020, 8'h54, 2));
    vecs.push_back(mk(0, ADD, 32'h0,         8'h00, 32'h0,         2'b11, 0, 1, 0, 32'h0000_0005, 0, 0, 2'b00, 32'h0040_0020, 8'h54, 2));
    vecs.push_back(mk(1, DIV, 32'h0000_1234, 8'h44, 32'h0000_0030, 2'b01, 0, 0, 1, 32'h0000_1234, 0, 0, 2'b00, 32'h0040_0020, 8'h54, 2));
    vecs.push_back(mk(0, ADD, 32'h0,         8'h00, 32'h0,         2'b00, 1, 0, 0, 32'h0000_1234, 0, 0, 2'b00, 32'h0040_0020, 8'h00, 2));
    vecs.push_back(mk(1, SUB, 32'h0000_AAAA, 8'h60, 32'h0000_0034, 2'b00, 0, 0, 1, 32'h0000_AAAA, 0, 0, 2'b00, 32'h0040_0020, 8'h60, 2));
    vecs.push_back(mk(1, ADD, 32'h0000_0001, 8'h80, 32'h0000_0038, 2'b00, 1, 0, 1, 32'h0000_0001, 0, 0, 2'b00, 32'h0040_0020, 8'h80, 2));
    vecs.push_back(mk(1, MUL, 32'h0000_0055, 8'h4B, 32'h0000_0044, 2'b01, 0, 0, 0, 32'h0000_0001, 1, 1, 2'b01, 32'h0000_0044, 8'hC0, 3));
    vecs.push_back(mk(1, ADD, 32'h0000_0066, 8'h20, 32'h0000_0048, 2'b01, 1, 1, 0, 32'h0000_0001, 0, 0, 2'b00, 32'h0000_0044, 8'h00, 3));
    vecs.push_back(mk(1, ADD, 32'h0000_0010, 8'h20, 32'h0000_004C, 2'b00, 0, 0, 1, 32'h0000_0010, 0, 0, 2'b00, 32'h0000_0044, 8'h20, 3));
    vecs.push_back(mk(1, ADD, 32'h0000_0011, 8'h10, 32'h0000_0050, 2'b00, 0, 0, 1, 32'h0000_0011, 0, 0, 2'b00, 32'h0000_0044, 8'h30, 3));
    vecs.push_back(mk(0, ADD, 32'h0,         8'h00, 32'h0,         2'b00, 0, 0, 0, 32'h0000_0011, 0, 0, 2'b00, 32'h0000_0044, 8'h30, 3));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while in TRAP aborts the trap without an ack.
    drive(mk(1, SUB, 32'h0000_0123, 8'h40, 32'h0000_0088, 2'b01, 0, 0,
             0, 32'h0000_0011, 1, 1, 2'b01, 32'h0000_0088, 8'h70, 4));
    check_outputs("pre_rst_trap", mk(1, SUB, 32'h0, 8'h40, 32'h0, 2'b01, 0, 0,
             0, 32'h0000_0011, 1, 1, 2'b01, 32'h0000_0088, 8'h70, 4));
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_in_trap", zero_v);
    reset = 1'b0;

    // A fresh op works normally after the aborted trap.
    drive(mk(1, ADD, 32'h0000_0042, 8'h80, 32'h0000_0090, 2'b01, 0, 0,
             1, 32'h0000_0042, 0, 0, 2'b00, 32'h0, 8'h80, 0));
    check_outputs("post_rst_op", mk(1, ADD, 32'h0, 8'h80, 32'h0, 2'b01, 0, 0,
             1, 32'h0000_0042, 0, 0, 2'b00, 32'h0, 8'h80, 0));

    idle_inputs();
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exception_unit.md
Name: alu_exception_unit

Overview:
- Sits directly downstream of the ALU in the EX stage.
- Registers each ALU result toward writeback and accumulates the ALU status flags into a sticky status register.
- Detects trapping conditions (signed overflow on add/sub/mul, divide-by-zero on div), captures the faulting PC and cause, and runs a request/acknowledge handshake with the control unit while stalling the pipeline.

Parameters:
- DATA_W, 32, width of ALU result and writeback data
- PC_W, 32, width of instruction address captured in EPC
- CNT_W, 16, width of the exception counter (optional feature only)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  ALU result/status/ctrl/pc valid this cycle
- ex_ctrl  input  4  ALU control code of the instruction (0010 add, 0110 sub, 1000 mul, 1001 div)
- ex_result  input  DATA_W  ALU result
- ex_status  input  8  ALU status: [7] zero, [6] overflow, [5] carry, [4] negative, [2] divide-by-zero; [3], [1], [0] ignored
- ex_pc  input  PC_W  PC of the instruction
- trap_mask  input  2  [0] enable overflow trap, [1] enable divide-by-zero trap
- status_clr  input  1  clear sticky status register
- exc_ack  input  1  control unit acknowledges exception
- wb_valid  output  1  registered writeback valid
- wb_result  output  DATA_W  registered writeback data
- stall  output  1  hold upstream pipeline
- exc_req  output  1  exception request to control unit
- exc_cause  output  2  00 none, 01 overflow, 10 divide-by-zero
- epc  output  PC_W  PC of faulting instruction
- sticky_status  output  8  OR-accumulated flags; bits [3], [1], [0] always 0
- exc_count  output  CNT_W  exception counter (optional feature only)

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-TRAP aborts the trap immediately with no ack required.
- Accepted op: ex_valid=1 while the FSM is in IDLE.
- Trap conditions:
  - ovf_trap = ex_status[6] & trap_mask[0] & ex_ctrl in {0010, 0110, 1000}.
  - dz_trap = ex_status[2] & trap_mask[1] & ex_ctrl == 1001.
  - If both hold, dz_trap wins and cause = 10.
- Writeback: latency is 1 cycle. For an accepted op with no trap, on the next edge wb_valid=1 and wb_result=ex_result. Otherwise wb_valid=0 and wb_result holds its previous value.
- FSM IDLE:
  - Accepted op with a trap condition: the next edge sets epc=ex_pc, exc_cause=code, exc_req=1, stall=1, wb_valid=0, and the FSM moves to TRAP. The faulting result is never written back.
- FSM TRAP:
  - exc_req and stall stay at 1; ex_valid is ignored (no writeback, no sticky update, no new trap).
  - exc_ack=1: the next edge clears exc_req, stall and exc_cause to 0, the FSM returns to IDLE, and epc holds its value.
  - An exc_ack seen in IDLE is ignored.
- stall is combinationally equal to (state == TRAP). It is asserted from the cycle after the faulting op through the cycle in which exc_ack is sampled.
- Sticky status:
  - On each accepted op, sticky_status |= ex_status & 8'b1111_0100. This includes the trapping op itself.
  - status_clr=1 zeroes the register at the edge.
  - When status_clr and an accepted op occur in the same cycle, the result is the new op's flags only (set-after-clear).
- Back-to-back accepted ops produce one wb_valid per cycle with no bubble.

Optional Feature:
- Macro: ALU_EXC_COUNTER_EN
- Defined: exc_count increments by 1 on every IDLE→TRAP transition and saturates at all-ones. It is cleared by reset only; status_clr does not affect it.
- Undefined: no counter register is built and exc_count is tied to 0.

Test Plan:
- Reset, then add with ex_result=32'h0000_0005, ex_status=0 → next cycle wb_valid=1, wb_result=5, stall=0, sticky_status=0.
- trap_mask=2'b01; add with ex_pc=32'h0040_0010, ex_status[6]=1, ex_status[4]=1 → next cycle exc_req=1, exc_cause=01, epc=32'h0040_0010, wb_valid=0, sticky_status=8'h50. Hold ex_valid=1 for 3 cycles: no wb_valid. Pulse exc_ack: the following cycle exc_req=0, stall=0.
- trap_mask=2'b11; div with ex_status=8'h44 (ovf and dz both set) → exc_cause=10. With trap_mask=2'b01 the same op gives wb_valid=1 and no trap.
- Sub with overflow and trap_mask=2'b00 → wb_valid=1, no exc_req, sticky_status[6]=1. Then status_clr together with an op carrying ex_status=8'h80 → sticky_status=8'h80.
- Assert reset while in TRAP → next cycle exc_req=0, stall=0, epc=0, sticky_status=0. With ALU_EXC_COUNTER_EN, three trap/ack sequences give exc_count=3, and reset returns it to 0.
